// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory port: port 0 is the CPU, port 1 the DMA/debug loader.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a GRANT watchdog that aborts with err after TIMEOUT_CYCLES.
module mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_rdy,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_rdy,
    output logic [DW-1:0] m1_rdata,
    output logic          s_req,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_we,
    input  logic          s_rdy,
    input  logic [DW-1:0] s_rdata,
    output logic [1:0]    grant,
    output logic          err
);

    // Handshake: a master holds mX_req with stable attributes until a one-cycle
    // mX_rdy; downstream s_req stays high with stable attributes until s_rdy,
    // and s_rdata is valid in the s_rdy cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   pick;
    logic   pick_valid;
    logic   expire;

    always_comb begin
        pick_valid = m0_req | m1_req;
        pick       = ~m0_req;
        if (m0_req && m1_req)
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    // The counter sits at zero in IDLE so it is cleared on entry to GRANT.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            to_cnt <= '0;
        else if (state != GRANT)
            to_cnt <= '0;
        else if (!s_rdy)
            to_cnt <= to_cnt + 1'b1;
    end

    assign expire = (state == GRANT) && !s_rdy && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            s_req      <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_we       <= 1'b0;
            m0_rdy     <= 1'b0;
            m1_rdy     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            grant      <= 2'b00;
            err        <= 1'b0;
        end else begin
            m0_rdy <= 1'b0;
            m1_rdy <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick;
                        last_grant <= pick;
                        s_req      <= 1'b1;
                        s_addr     <= pick ? m1_addr  : m0_addr;
                        s_wdata    <= pick ? m1_wdata : m0_wdata;
                        s_we       <= pick ? m1_we    : m0_we;
                        grant      <= pick ? 2'b10    : 2'b01;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    // s_rdy in the expiry cycle takes precedence over the abort.
                    if (s_rdy) begin
                        s_req <= 1'b0;
                        s_we  <= 1'b0;
                        if (owner) begin
                            m1_rdata <= s_rdata;
                            m1_rdy   <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_rdy   <= 1'b1;
                        end
                        state <= RESP;
                    end else if (expire) begin
                        s_req <= 1'b0;
                        s_we  <= 1'b0;
                        err   <= 1'b1;
                        if (owner) begin
                            m1_rdata <= '0;
                            m1_rdy   <= 1'b1;
                        end else begin
                            m0_rdata <= '0;
                            m0_rdy   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    s_req <= 1'b0;
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance run in lockstep on shared stimulus.
// Build with MEM_ARB_TIMEOUT_EN defined to exercise the watchdog abort (TIMEOUT_CYCLES=4).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int MAXLAT = TO;
`else
    localparam int MAXLAT = 8;
`endif

    logic          clk, sys_rst_n;
    logic          m0_req, m0_we, m1_req, m1_we, s_rdy;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_rdata;
    logic          m0_rdy, m1_rdy, s_req, s_we, err;
    logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
    logic [AW-1:0] s_addr;
    logic [1:0]    grant;
    logic          f_m0_rdy, f_m1_rdy, f_s_req, f_s_we, f_err;
    logic [DW-1:0] f_m0_rdata, f_m1_rdata, f_s_wdata;
    logic [AW-1:0] f_s_addr;
    logic [1:0]    f_grant;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic          last_g;
    logic [DW-1:0] exp_rd[2];
    logic [DW-1:0] exp_frd[2];
    logic [DW-1:0] exp_q[$];

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_rdy(m0_rdy), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_rdy(m1_rdy), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_rdy(s_rdy), .s_rdata(s_rdata), .grant(grant), .err(err)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(TO)) u_fix (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_rdy(f_m0_rdy), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_rdy(f_m1_rdy), .m1_rdata(f_m1_rdata),
        .s_req(f_s_req), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_we(f_s_we),
        .s_rdy(s_rdy), .s_rdata(s_rdata), .grant(f_grant), .err(f_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sreq"}, 64'(s_req), 64'd0);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_rdy"}, 64'({m1_rdy, m0_rdy}), 64'd0);
        chk({tag, "_frdy"}, 64'({f_m1_rdy, f_m0_rdy}), 64'd0);
    endtask

    // One transaction from an IDLE cycle through RESP back to IDLE.
    // pat: 1 = port 0 only, 2 = port 1 only, 3 = both request.
    task automatic run_txn(input string tag, input int pat, input int lat, input bit drop,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic we0, input logic we1, input logic [DW-1:0] rd);
        int            own, fown;
        logic [AW-1:0] a[2];
        logic [DW-1:0] w[2];
        logic          we[2];
        a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1; we[0] = we0; we[1] = we1;
        m0_req = pat[0]; m1_req = pat[1];
        m0_addr = a0; m1_addr = a1; m0_wdata = w0; m1_wdata = w1; m0_we = we0; m1_we = we1;
        if (pat == 3) own = last_g ? 0 : 1;
        else own = (pat == 2) ? 1 : 0;
        fown   = (pat == 3) ? 0 : own;
        last_g = own[0];
        step();
        for (int c = 1; c <= lat; c++) begin
            chk({tag, "_sreq"}, 64'(s_req), 64'd1);
            chk({tag, "_grant"}, 64'(grant), (own == 1) ? 64'd2 : 64'd1);
            chk({tag, "_saddr"}, 64'(s_addr), 64'(a[own]));
            chk({tag, "_swdata"}, 64'(s_wdata), 64'(w[own]));
            chk({tag, "_swe"}, 64'(s_we), 64'(we[own]));
            chk({tag, "_rdy_g"}, 64'({m1_rdy, m0_rdy}), 64'd0);
            chk({tag, "_fgrant"}, 64'(f_grant), (fown == 1) ? 64'd2 : 64'd1);
            chk({tag, "_fsreq"}, 64'(f_s_req), 64'd1);
            chk({tag, "_fsaddr"}, 64'(f_s_addr), 64'(a[fown]));
            chk({tag, "_fswdata"}, 64'(f_s_wdata), 64'(w[fown]));
            chk({tag, "_fswe"}, 64'(f_s_we), 64'(we[fown]));
            if (c == 1) begin
                m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
                m0_we = ~we0; m1_we = ~we1;
                if (drop) begin m0_req = 1'b0; m1_req = 1'b0; end
            end
            if (c == lat) begin
                s_rdy = 1'b1; s_rdata = rd; exp_q.push_back(rd);
            end
            step();
        end
        s_rdy = 1'b0; s_rdata = $urandom;
        chk({tag, "_sreq_r"}, 64'(s_req), 64'd0);
        chk({tag, "_rdy_r"}, 64'({m1_rdy, m0_rdy}), (own == 1) ? 64'd2 : 64'd1);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_grant_r"}, 64'(grant), (own == 1) ? 64'd2 : 64'd1);
        chk({tag, "_rdata"}, 64'(own == 1 ? m1_rdata : m0_rdata), 64'(exp_q.pop_front()));
        chk({tag, "_hold"}, 64'(own == 1 ? m0_rdata : m1_rdata), 64'(exp_rd[1-own]));
        chk({tag, "_frdy"}, 64'({f_m1_rdy, f_m0_rdy}), (fown == 1) ? 64'd2 : 64'd1);
        chk({tag, "_frdata"}, 64'(fown == 1 ? f_m1_rdata : f_m0_rdata), 64'(rd));
        chk({tag, "_ferr"}, 64'(f_err), 64'd0);
        exp_rd[own]   = rd;
        exp_frd[fown] = rd;
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        chk_quiet({tag, "_idle"});
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic run_timeout();
        m0_req = 1'b1; m1_req = 1'b0; m0_addr = 32'h80; m0_we = 1'b0;
        last_g = 1'b0;
        step();
        for (int c = 1; c <= TO; c++) begin
            chk("to_sreq", 64'(s_req), 64'd1);
            step();
        end
        chk("to_sreq_drop", 64'(s_req), 64'd0);
        chk("to_rdy", 64'({m1_rdy, m0_rdy}), 64'd1);
        chk("to_err", 64'(err), 64'd1);
        chk("to_rdata", 64'(m0_rdata), 64'd0);
        chk("to_ferr", 64'(f_err), 64'd1);
        chk("to_frdata", 64'(f_m0_rdata), 64'd0);
        exp_rd[0] = '0; exp_frd[0] = '0;
        m0_req = 1'b0;
        step();
        chk("to_err_clr", 64'(err), 64'd0);
        chk_quiet("to_idle");
    endtask
`endif

    initial begin
        sys_rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        s_rdy = 1'b0; s_rdata = '0;
        last_g = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_frd[0] = '0; exp_frd[1] = '0;
        #12;
        chk_quiet("reset");
        chk("reset_rdata", 64'({m1_rdata, m0_rdata}), 64'd0);
        chk("reset_s", 64'({s_we, s_addr, s_wdata}), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;

        // Tie out of reset: strict alternation, one completion every 3 cycles
        for (int i = 0; i < 4; i++)
            run_txn("tie", 3, 1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);

        run_txn("m0_read", 1, 2, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        run_txn("m1_write", 2, 3, 1'b0, 32'h0, 32'h100, 32'h0, 32'h1234_5678, 1'b0, 1'b1, $urandom);
        run_txn("drop_req", 2, 2, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);

        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                chk_quiet("gap");
            end
            run_txn("rand", $urandom_range(1, 3), $urandom_range(1, MAXLAT), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        run_timeout();
        run_txn("to_last", 1, TO, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);
`else
        run_txn("long_wait", 1, 20, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);
`endif

        // Reset while granted: s_req drops asynchronously and no rdy follows
        m0_req = 1'b1; m1_req = 1'b0;
        step();
        chk("rst_pre_sreq", 64'(s_req), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_rdata", 64'({m1_rdata, m0_rdata}), 64'd0);
        last_g = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_frd[0] = '0; exp_frd[1] = '0;
        m0_req = 1'b0;
        step();
        chk_quiet("rst_hold");
        sys_rst_n = 1'b1;
        step();
        chk_quiet("rst_after");
        run_txn("rst_tie", 3, 1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom);
        run_txn("rst_tie2", 3, 2, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
